fir_tap_delay_line: RTL and testbench
=====================================

Name: fir_tap_delay_line

Overview:
Streaming tap delay line directly upstream of the adaptive FIR MAC pipeline. It accepts one signed fixed-point sample per handshake and shifts it into a FILTER_LENGTH-deep register line. It presents the whole line as the packed taps bus with valid/ready handshaking. Output valid is withheld until the line is primed, and a synchronous flush re-primes it.

Parameters:
FILTER_LENGTH, 32, number of taps; any value >= 2.
FXP_WIDTH, 16, sample width, two's complement.
TAP_BUS_WIDTH, FILTER_LENGTH*FXP_WIDTH, width of the packed taps bus.
CNT_WIDTH, $clog2(FILTER_LENGTH+1), width of the fill counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
s_sample  in  FXP_WIDTH  incoming signed sample.
s_valid  in  1  s_sample is valid.
s_ready  out  1  block can accept a sample this cycle.
flush  in  1  synchronous clear of the line and fill count.
taps_out  out  TAP_BUS_WIDTH  packed taps; tap i at [(i+1)*FXP_WIDTH-1 -: FXP_WIDTH]; tap0 is the newest sample.
taps_valid  out  1  taps_out holds a complete, primed window.
taps_ready  in  1  downstream consumes taps_out this cycle.
fill_level  out  CNT_WIDTH  samples held, saturating at FILTER_LENGTH.
primed  out  1  fill_level == FILTER_LENGTH.

Behaviour:
- Reset (async, rst_n low): all taps 0, fill_level 0, taps_valid 0, primed 0. s_ready is 0 while rst_n is low and 1 from the first cycle after release.
- s_ready = !flush && (!taps_valid || taps_ready). This is combinational and gives one-entry pipeline semantics.
- Accept = s_valid && s_ready. On accept:
  - tap[i] <= tap[i-1] for i >= 1; tap0 <= s_sample.
  - fill_level increments, saturating at FILTER_LENGTH.
- States: PRIME (fill_level < FILTER_LENGTH) and STREAM (fill_level == FILTER_LENGTH). PRIME moves to STREAM on the accept that makes fill_level reach FILTER_LENGTH. STREAM moves to PRIME only on flush or reset.
- taps_valid (registered):
  - Set on the cycle after an accept whose resulting fill_level == FILTER_LENGTH.
  - Cleared on the cycle after taps_ready && taps_valid with no new accept.
  - Accept and consume in the same cycle: taps_valid stays 1 and taps_out advances.
- Latency: sample accepted in cycle N appears at tap0 with taps_valid in cycle N+1, once primed.
- taps_out is stable while taps_valid && !taps_ready. No shift occurs, because s_ready is 0.
- In PRIME the line still shifts on accept, but taps_valid stays 0. Partial windows are never exposed.
- flush (synchronous) has priority over accept. Because s_ready = 0 during flush, a sample presented that cycle is not taken. Next cycle: taps 0, fill_level 0, taps_valid 0, state PRIME.
- Reset mid-stream: immediate clear; any pending window is discarded.
- Arithmetic: no scaling or saturation of samples; bits are copied verbatim.

Optional Feature:
Macro TAP_ZERO_PRIME_EN.
- Defined: PRIME state is skipped for output purposes. taps_valid is set from the first accept, with unfilled taps reading as zero (zero-initial-condition FIR). fill_level and primed still track fill as normal.
- Not defined: behaviour is exactly as in Behaviour; no output until FILTER_LENGTH samples are held.

Test Plan:
(All scenarios use FILTER_LENGTH=4, FXP_WIDTH=16.)
1. Priming: send 1,2,3,4 back-to-back with taps_ready=1.
   - taps_valid is 0 until the cycle after sample 4.
   - Then taps_out taps0..3 = 4,3,2,1; primed=1; fill_level=4.
2. Streaming throughput: continue with 5,6,7 with taps_ready=1 held.
   - One window per cycle: (5,4,3,2), (6,5,4,3), (7,6,5,4).
   - s_ready stays 1 throughout.
3. Backpressure: after priming, drop taps_ready for 3 cycles while s_valid=1 with sample 0x8000.
   - s_ready=0 and taps_out is held unchanged.
   - On taps_ready=1, 0x8000 is accepted next and appears at tap0 with sign preserved.
4. Flush: in STREAM, assert flush for 1 cycle with s_valid=1 and sample 9.
   - 9 is not accepted.
   - Next cycle: taps all 0, fill_level=0, taps_valid=0.
   - Four new samples are required before taps_valid returns.
5. Async reset mid-stream: pull rst_n low between clock edges while taps_valid=1.
   - Outputs clear immediately without a clock edge.
   - After release, behaviour matches scenario 1.
6. TAP_ZERO_PRIME_EN build: send sample 7.
   - Next cycle taps_valid=1 with taps_out = (7,0,0,0) and fill_level=1.

Source files
------------

// File: rtl/fir_tap_delay_line.sv
// rtl/fir_tap_delay_line.sv - streaming tap delay line feeding the adaptive FIR MAC
//
// Shifts one signed sample per accepted handshake into a FILTER_LENGTH-deep line.
// The whole line is presented as a packed window. The window is marked valid only
// once the line is primed.
//
// Optional build macro: TAP_ZERO_PRIME_EN
//   When defined, windows are exposed from the first accepted sample, and unfilled
//   taps read as zero.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   s_sample    incoming signed sample
//   s_valid     s_sample is valid
//   s_ready     a sample can be accepted this cycle
//   flush       synchronous clear of the line and fill count
//   taps_out    packed taps; tap i at [(i+1)*FXP_WIDTH-1 -: FXP_WIDTH], tap0 newest
//   taps_valid  taps_out holds an exposable window
//   taps_ready  downstream consumes taps_out this cycle
//   fill_level  samples held, saturating at FILTER_LENGTH
//   primed      line holds FILTER_LENGTH samples
module fir_tap_delay_line #(
  parameter int FILTER_LENGTH = 32,
  parameter int FXP_WIDTH     = 16,
  parameter int TAP_BUS_WIDTH = FILTER_LENGTH * FXP_WIDTH,
  parameter int CNT_WIDTH     = $clog2(FILTER_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FXP_WIDTH-1:0]     s_sample,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     flush,
  output logic [TAP_BUS_WIDTH-1:0] taps_out,
  output logic                     taps_valid,
  input  logic                     taps_ready,
  output logic [CNT_WIDTH-1:0]     fill_level,
  output logic                     primed
);

  typedef enum logic {PRIME, STREAM} state_t;

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FILTER_LENGTH);

  state_t                   state, state_next;
  logic [CNT_WIDTH-1:0]     fill_q, fill_next;
  logic                     valid_q, valid_next;
  logic [TAP_BUS_WIDTH-1:0] line_q;
  logic                     accept;

  // One-entry pipeline: a new sample may enter only when the current window is
  // absent or is being consumed. The rst_n term keeps s_ready low during reset.
  assign s_ready = rst_n && !flush && (!valid_q || taps_ready);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PRIME;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      fill_q  <= fill_next;
      valid_q <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    fill_next  = fill_q;
    valid_next = valid_q;
    if (flush) begin
      state_next = PRIME;
      fill_next  = '0;
      valid_next = 1'b0;
    end else if (accept) begin
      if (fill_q != FULL) begin
        fill_next = fill_q + 1'b1;
      end
      case (state)
        PRIME:   if (fill_q == FULL - 1'b1) state_next = STREAM;
        STREAM:  state_next = STREAM;
        default: state_next = PRIME;
      endcase
`ifdef TAP_ZERO_PRIME_EN
      valid_next = 1'b1;
`else
      // The window becomes valid on the accept that fills the line, and it stays
      // valid on every later accept.
      valid_next = (state == STREAM) || (fill_q == FULL - 1'b1);
`endif
    end else if (taps_ready && valid_q) begin
      valid_next = 1'b0;
    end
  end

  // Tap0 occupies the low bits, so a shift moves every tap up one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (flush) begin
      line_q <= '0;
    end else if (accept) begin
      line_q <= {line_q[TAP_BUS_WIDTH-FXP_WIDTH-1:0], s_sample};
    end
  end

  assign taps_out   = line_q;
  assign taps_valid = valid_q;
  assign fill_level = fill_q;
  assign primed     = (state == STREAM);

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// tb/tb_fir_tap_delay_line.sv - randomized self-checking bench for fir_tap_delay_line
module tb_fir_tap_delay_line;

  localparam int L  = 4;
  localparam int W  = 16;
  localparam int BW = L * W;
  localparam int CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_sample;
  logic          s_valid;
  logic          s_ready;
  logic          flush;
  logic [BW-1:0] taps_out;
  logic          taps_valid;
  logic          taps_ready;
  logic [CW-1:0] fill_level;
  logic          primed;

  fir_tap_delay_line #(
    .FILTER_LENGTH(L),
    .FXP_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_sample(s_sample),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .flush(flush),
    .taps_out(taps_out),
    .taps_valid(taps_valid),
    .taps_ready(taps_ready),
    .fill_level(fill_level),
    .primed(primed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // The reference model is a history of samples (newest first), a count of
  // samples received and a flag that records whether a window is exposed.
  logic [W-1:0] hist[$];
  int           m_cnt;
  logic         m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_taps();
    logic [63:0] r = '0;
    for (int i = 0; i < L; i++)
      if (i < hist.size()) r[i*W +: W] = hist[i];
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt   = 0;
    m_valid = 1'b0;
  endtask

  task automatic check_state(input string pfx);
    chk({pfx, "taps_out"},   64'(taps_out),   model_taps());
    chk({pfx, "taps_valid"}, 64'(taps_valid), 64'(m_valid));
    chk({pfx, "fill_level"}, 64'(fill_level), 64'(m_cnt));
    chk({pfx, "primed"},     64'(primed),     64'(m_cnt == L));
  endtask

  // Drive one cycle at the falling edge, check, then advance the model to
  // what the next rising edge should produce.
  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    logic exp_ready;
    logic acc;
    @(negedge clk);
    s_valid = v; s_sample = d; flush = f; taps_ready = r;
    #1;
    exp_ready = !f && (!m_valid || r);
    acc = v && exp_ready;
    check_state("");
    chk("s_ready", 64'(s_ready), 64'(exp_ready));
    if (f) begin
      model_reset();
    end else if (acc) begin
      hist.push_front(d);
      if (hist.size() > L) void'(hist.pop_back());
      if (m_cnt < L) m_cnt++;
`ifdef TAP_ZERO_PRIME_EN
      m_valid = 1'b1;
`else
      m_valid = (m_cnt == L);
`endif
    end else if (r && m_valid) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sample = '0; flush = 1'b0; taps_ready = 1'b0;
    model_reset();
    #12;
    check_state("reset_");
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Priming, then streaming
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    step(1'b1, 16'd5, 1'b0, 1'b1);
`ifndef TAP_ZERO_PRIME_EN
    chk("prime_window", 64'(taps_out), {16'd1, 16'd2, 16'd3, 16'd4});
`endif
    step(1'b1, 16'd6, 1'b0, 1'b1);
    step(1'b1, 16'd7, 1'b0, 1'b1);
    chk("stream_window", 64'(taps_out), {16'd3, 16'd4, 16'd5, 16'd6});

    // Backpressure with a negative sample
    for (int i = 0; i < 3; i++) step(1'b1, 16'h8000, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("neg_tap0", 64'(taps_out[15:0]), 64'h8000);

    // Flush in STREAM with a sample presented
    for (int i = 10; i < 13; i++) step(1'b1, W'(i), 1'b0, 1'b1);
    step(1'b1, 16'd9, 1'b1, 1'b1);
    for (int i = 20; i < 25; i++) step(1'b1, W'(i), 1'b0, 1'b1);

    // Asynchronous reset between clock edges while a window is exposed
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b0; taps_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst_");
    chk("async_rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
